// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: redirect, imem request/response, sequential-PC adder and decode handoff.
// Trap outputs exist only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_pc_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] sum_a;
  logic [31:0] sum_b;
  logic [31:0] sum_result;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
  logic [31:0] fetch_bad_pc;
`endif

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, sum_result, if_ready,
    output imem_req, imem_addr, sum_a, sum_b, if_valid, if_pc, if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    , output fetch_misaligned, fetch_bad_pc
`endif
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, sum_result, if_ready,
    input  imem_req, imem_addr, sum_a, sum_b, if_valid, if_pc, if_instr
`ifdef FETCH_MISALIGN_TRAP_EN
    , input fetch_misaligned, fetch_bad_pc
`endif
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction fetch: one outstanding imem read, request-to-if_valid 2 cycles min; holds {pc,instr} while if_ready=0.
// Redirects discard in-flight fetches; FETCH_MISALIGN_TRAP_EN makes misaligned redirects halt instead of truncating.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic             clk,
  input logic             reset,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_OUT, S_DROP, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        if_valid_q, if_valid_nxt;
  logic [31:0] if_pc_q, if_pc_nxt;
  logic [31:0] if_instr_q, if_instr_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned_q, misaligned_nxt;
  logic [31:0] bad_pc_q, bad_pc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
      bad_pc_q     <= 32'h0;
`endif
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      if_valid_q <= if_valid_nxt;
      if_pc_q    <= if_pc_nxt;
      if_instr_q <= if_instr_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_nxt;
      bad_pc_q     <= bad_pc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_valid_nxt = if_valid_q;
    if_pc_nxt    = if_pc_q;
    if_instr_nxt = if_instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_nxt = misaligned_q;
    bad_pc_nxt     = bad_pc_q;
`endif

    case (state)
      S_REQ:  if (bus.imem_gnt) state_nxt = S_WAIT;
      S_WAIT: if (bus.imem_rvalid) begin
                if_instr_nxt = bus.imem_rdata;
                if_pc_nxt    = pc;
                pc_nxt       = bus.sum_result;
                if_valid_nxt = 1'b1;
                state_nxt    = S_OUT;
              end
      S_OUT:  if (bus.if_ready) begin
                if_valid_nxt = 1'b0;
                state_nxt    = S_REQ;
              end
      S_DROP: if (bus.imem_rvalid) state_nxt = S_REQ;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_REQ;
    endcase

    // A redirect overrides whatever the sequential flow decided, including a same-cycle response.
    if (bus.redirect_valid && state != S_HALT) begin
      if_valid_nxt = 1'b0;
      if_pc_nxt    = if_pc_q;
      if_instr_nxt = if_instr_q;
      case (state)
        S_REQ:   state_nxt = bus.imem_gnt    ? S_DROP : S_REQ;
        S_WAIT:  state_nxt = bus.imem_rvalid ? S_REQ  : S_DROP;
        S_DROP:  state_nxt = bus.imem_rvalid ? S_REQ  : S_DROP;
        default: state_nxt = S_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_nxt      = S_HALT;
        pc_nxt         = pc;
        misaligned_nxt = 1'b1;
        bad_pc_nxt     = bus.redirect_pc;
      end else begin
        pc_nxt = {bus.redirect_pc[31:2], 2'b00};
      end
`else
      pc_nxt = {bus.redirect_pc[31:2], 2'b00};
`endif
    end
  end

  assign bus.imem_req  = (state == S_REQ) && !reset;
  assign bus.imem_addr = pc;
  assign bus.sum_a     = pc;
  assign bus.sum_b     = PC_STEP;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.fetch_misaligned = misaligned_q;
  assign bus.fetch_bad_pc     = bad_pc_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic checked against a transaction-level model.
// Builds with or without FETCH_MISALIGN_TRAP_EN.
module tb_fetch_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_unit_if bus();
  assign bus.sum_result = bus.sum_a + bus.sum_b;

  fetch_pc_unit #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: what the fetch unit owes the outside world, in transaction terms.
  logic        m_out;        // a granted request has not been answered yet
  logic        m_kill;       // that request was overtaken by a redirect
  logic [31:0] m_out_addr;
  logic        m_pend;       // a delivery awaits decode
  logic [31:0] m_pend_pc, m_pend_instr;
  logic [31:0] m_addr;       // address of the next request (= pc)
  logic        m_halt;
  logic [31:0] m_bad;

  task automatic cycle(input logic rst, input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic redir, input logic [31:0] rpc, input logic rdy);
    logic rv_g, exp_req, hs, live, mis;
    @(posedge clk);
    #1;
    rv_g = rv && m_out && !rst;
    reset              = rst;
    bus.imem_gnt       = gnt;
    bus.imem_rvalid    = rv_g;
    bus.imem_rdata     = rdata;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    @(negedge clk);
    if (rst) begin
      chk("req_in_reset", {31'h0, bus.imem_req}, 32'h0);
      m_out = 1'b0; m_kill = 1'b0; m_pend = 1'b0; m_addr = RST_PC; m_halt = 1'b0; m_bad = 32'h0;
    end else begin
      exp_req = !m_halt && !m_out && !m_pend;
      chk("imem_req", {31'h0, bus.imem_req}, {31'h0, exp_req});
      if (exp_req) chk("imem_addr", bus.imem_addr, m_addr);
      chk("sum_a", bus.sum_a, m_addr);
      chk("sum_b", bus.sum_b, 32'd4);
      chk("if_valid", {31'h0, bus.if_valid}, {31'h0, m_pend});
      if (m_pend) begin
        chk("if_pc", bus.if_pc, m_pend_pc);
        chk("if_instr", bus.if_instr, m_pend_instr);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fetch_misaligned", {31'h0, bus.fetch_misaligned}, {31'h0, m_halt});
      if (m_halt) chk("fetch_bad_pc", bus.fetch_bad_pc, m_bad);
`endif
      hs   = m_pend && rdy;
      live = rv_g && !m_kill && !m_halt && !redir;
      if (hs) m_pend = 1'b0;
      if (rv_g) m_out = 1'b0;
      if (live) begin
        m_pend       = 1'b1;
        m_pend_pc    = m_out_addr;
        m_pend_instr = rdata;
        m_addr       = m_out_addr + 32'd4;
      end
      if (exp_req && gnt) begin
        m_out      = 1'b1;
        m_out_addr = m_addr;
        m_kill     = 1'b0;
      end
      mis = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis = (rpc[1:0] != 2'b00);
`endif
      if (redir && !m_halt) begin
        if (mis) begin
          m_halt = 1'b1;
          m_bad  = rpc;
        end else begin
          m_addr = {rpc[31:2], 2'b00};
        end
        m_kill = 1'b1;
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic step(input logic gnt, input logic rv, input logic [31:0] rdata,
                      input logic redir, input logic [31:0] rpc, input logic rdy);
    cycle(1'b0, gnt, rv, rdata, redir, rpc, rdy);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] rpc;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.if_ready = 1'b0;
    m_out = 1'b0; m_kill = 1'b0; m_pend = 1'b0; m_out_addr = 32'h0;
    m_pend_pc = 32'h0; m_pend_instr = 32'h0; m_addr = RST_PC; m_halt = 1'b0; m_bad = 32'h0;

    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle();
    chk("rst_if_valid", {31'h0, bus.if_valid}, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_addr", bus.imem_addr, RST_PC);

    // Back-to-back sequential fetches at minimum latency.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("seq_addr", bus.imem_addr, 32'(4 * i));
      step(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("seq_pc", bus.if_pc, 32'(4 * i));
      chk("seq_instr", bus.if_instr, 32'hA000_0000 + 32'(i));
    end

    // Decode stalls for five cycles.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hBEEF_0010, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      chk("stall_pc", bus.if_pc, 32'h10);
      chk("stall_req", {31'h0, bus.imem_req}, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Redirect while waiting; late response must be dropped.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    idle();
    step(1'b0, 1'b1, 32'hDEAD_DEAD, 1'b0, 32'h0, 1'b0);
    idle();
    chk("redir_wait_addr", bus.imem_addr, 32'h100);
    chk("redir_wait_vld", {31'h0, bus.if_valid}, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("redir_wait_pc", bus.if_pc, 32'h100);

    // Redirect coinciding with grant, then with rvalid.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_0001, 1'b0, 32'h0, 1'b0);
    idle();
    chk("redir_gnt_addr", bus.imem_addr, 32'h200);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'hDEAD_0002, 1'b1, 32'h300, 1'b0);
    idle();
    chk("redir_rv_vld", {31'h0, bus.if_valid}, 32'h0);
    chk("redir_rv_addr", bus.imem_addr, 32'h300);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc", bus.if_pc, 32'hFFFF_FFFC);
    idle();
    chk("wrap_next_addr", bus.imem_addr, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom;
      if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      cycle($urandom_range(249) == 0, $urandom_range(2) != 0, $urandom_range(1) == 1, $urandom,
            $urandom_range(9) == 0, rpc, $urandom_range(2) != 0);
    end

    // Misaligned redirect target.
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h103, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'h0, 1'b1, 32'h400, 1'b1);
      chk("halt_req", {31'h0, bus.imem_req}, 32'h0);
      chk("halt_flag", {31'h0, bus.fetch_misaligned}, 32'h1);
      chk("halt_bad_pc", bus.fetch_bad_pc, 32'h103);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle();
    chk("halt_cleared", {31'h0, bus.fetch_misaligned}, 32'h0);
    chk("halt_exit_req", {31'h0, bus.imem_req}, 32'h1);
`else
    idle();
    chk("misalign_addr", bus.imem_addr, 32'h100);
    chk("misalign_req", {31'h0, bus.imem_req}, 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
